// File: rtl/updown_cnt_mod.sv
`default_nettype none
// ============================================================================
//  Module   : updown_cnt_mod
//  Purpose  : Modulo-N up/down counter with programmable step, wrap/saturate
//             mode, clamped load, terminal count and registered boundary pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module updown_cnt_mod #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10,
    parameter int STEP_W  = 3,
    parameter int RST_VAL = 0
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              sclr,
    input  logic              load,
    input  logic              cnt_en,
    input  logic              dir,
    input  logic              sat,
    input  logic [STEP_W-1:0] step,
    input  logic [WIDTH-1:0]  din,
    output logic [WIDTH-1:0]  cnt_qout,
    output logic              tc,
    output logic              evt
);

    // Step comparison width must hold both the raw step and MODULUS-1.
    localparam int EW = (STEP_W > WIDTH + 1) ? STEP_W : WIDTH + 1;

    localparam logic [EW-1:0]    c_SMAX  = EW'(MODULUS - 1);
    localparam logic [WIDTH:0]   c_MOD   = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH:0]   c_TOP   = (WIDTH + 1)'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_TOP_Q = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_RST   = WIDTH'(RST_VAL);

    logic [WIDTH-1:0] r_q;
    logic             r_evt;

    logic [EW-1:0]    w_step_e;
    logic [WIDTH:0]   w_s;
    logic [WIDTH:0]   w_q_e;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_load_q;
    logic [WIDTH-1:0] w_cnt_q;
    logic             w_cnt_evt;

    assign w_step_e = EW'(step);
    assign w_s      = (WIDTH + 1)'((w_step_e > c_SMAX) ? c_SMAX : w_step_e);
    assign w_q_e    = {1'b0, r_q};
    assign w_sum    = w_q_e + w_s;
    assign w_load_q = ({1'b0, din} < c_MOD) ? din : c_TOP_Q;

    always_comb begin
        w_cnt_q   = r_q;
        w_cnt_evt = 1'b0;
        if (dir) begin
            if (w_sum <= c_TOP) begin
                w_cnt_q = WIDTH'(w_sum);
            end else begin
                w_cnt_evt = 1'b1;
                w_cnt_q   = sat ? c_TOP_Q : WIDTH'(w_sum - c_MOD);
            end
        end else begin
            if (w_q_e >= w_s) begin
                w_cnt_q = WIDTH'(w_q_e - w_s);
            end else begin
                // q < s here, so q+MODULUS-s stays inside WIDTH+1 bits.
                w_cnt_evt = 1'b1;
                w_cnt_q   = sat ? '0 : WIDTH'(w_q_e + c_MOD - w_s);
            end
        end
    end

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            r_q   <= c_RST;
            r_evt <= 1'b0;
        end else if (sclr) begin
            r_q   <= '0;
            r_evt <= 1'b0;
        end else if (load) begin
            r_q   <= w_load_q;
            r_evt <= 1'b0;
        end else if (cnt_en) begin
            r_q   <= w_cnt_q;
            r_evt <= w_cnt_evt;
        end else begin
            r_evt <= 1'b0;
        end
    end

    assign cnt_qout = r_q;
    assign evt      = r_evt;
    assign tc       = dir ? (r_q == c_TOP_Q) : (r_q == '0);

endmodule
`default_nettype wire

// File: tb/tb_updown_cnt_mod.sv
`default_nettype none
// ============================================================================
//  Module   : tb_updown_cnt_mod
//  Purpose  : Self-checking bench for updown_cnt_mod (MODULUS 10 and 16).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_updown_cnt_mod;

    logic       clk = 1'b0;
    logic       aclr, sclr, load, cnt_en, dir, sat;
    logic [2:0] step;
    logic [3:0] din;
    logic [3:0] q10, q16;
    logic       tc10, tc16, evt10, evt16;

    int n_checks = 0;
    int n_fail   = 0;
    int mq10, me10, mq16, me16;

    always #5 clk = ~clk;

    updown_cnt_mod #(.WIDTH(4), .MODULUS(10), .STEP_W(3), .RST_VAL(0)) dut10 (
        .clk(clk), .aclr(aclr), .sclr(sclr), .load(load), .cnt_en(cnt_en),
        .dir(dir), .sat(sat), .step(step), .din(din),
        .cnt_qout(q10), .tc(tc10), .evt(evt10)
    );

    updown_cnt_mod #(.WIDTH(4), .MODULUS(16), .STEP_W(3), .RST_VAL(0)) dut16 (
        .clk(clk), .aclr(aclr), .sclr(sclr), .load(load), .cnt_en(cnt_en),
        .dir(dir), .sat(sat), .step(step), .din(din),
        .cnt_qout(q16), .tc(tc16), .evt(evt16)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: one clock edge of a modulo-mod counter, straight from the rules.
    task automatic model_step(input int mod, inout int q, inout int e);
        int s;
        s = (int'(step) > mod - 1) ? mod - 1 : int'(step);
        e = 0;
        if (sclr)        q = 0;
        else if (load)   q = (int'(din) < mod) ? int'(din) : mod - 1;
        else if (cnt_en) begin
            if (dir) begin
                if (q + s <= mod - 1) q = q + s;
                else begin e = 1; q = sat ? mod - 1 : q + s - mod; end
            end else begin
                if (q >= s) q = q - s;
                else begin e = 1; q = sat ? 0 : q - s + mod; end
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_q10"},   int'(q10),   mq10);
        check({tag, "_evt10"}, int'(evt10), me10);
        check({tag, "_tc10"},  int'(tc10),  (dir ? (mq10 == 9) : (mq10 == 0)) ? 1 : 0);
        check({tag, "_q16"},   int'(q16),   mq16);
        check({tag, "_evt16"}, int'(evt16), me16);
        check({tag, "_tc16"},  int'(tc16),  (dir ? (mq16 == 15) : (mq16 == 0)) ? 1 : 0);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        #1;
        model_step(10, mq10, me10);
        model_step(16, mq16, me16);
        check_all(tag);
    endtask

    // Asynchronous clear mid-cycle, held across one counting edge.
    task automatic do_aclr(input string tag);
        #3;
        aclr = 1'b1;
        #1;
        mq10 = 0; me10 = 0; mq16 = 0; me16 = 0;
        check_all({tag, "_async"});
        @(posedge clk);
        #1;
        check_all({tag, "_held"});
        aclr = 1'b0;
    endtask

    task automatic set_in(input logic s_clr, input logic s_load, input logic s_en,
                          input logic s_dir, input logic s_sat, input int s_step, input int s_din);
        sclr = s_clr; load = s_load; cnt_en = s_en; dir = s_dir; sat = s_sat;
        step = 3'(s_step); din = 4'(s_din);
    endtask

    initial begin
        aclr = 1'b1;
        set_in(0, 0, 1, 1, 0, 1, 0);
        mq10 = 0; me10 = 0; mq16 = 0; me16 = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all("rst");
        aclr = 1'b0;

        // Priority: sclr beats load beats count.
        set_in(0, 1, 1, 1, 0, 3, 5); tick("ld5");
        set_in(1, 1, 1, 1, 0, 3, 7); tick("sclr_pri");
        check("sclr_pri_const", int'(q10), 0);
        set_in(0, 1, 1, 1, 0, 3, 4); tick("ld4");
        do_aclr("aclr1");

        // Up-count wrap.
        set_in(0, 1, 0, 1, 0, 2, 7); tick("t2_ld");
        set_in(0, 0, 1, 1, 0, 2, 0); tick("t2_a");
        check("t2_nine", int'(q10), 9);
        check("t2_tc", int'(tc10), 1);
        tick("t2_b");
        check("t2_wrap", int'(q10), 1);
        check("t2_evt", int'(evt10), 1);
        set_in(0, 0, 0, 1, 0, 2, 0); tick("t2_idle");

        // Down-count saturate, then tc follows dir without a clock.
        set_in(0, 1, 0, 0, 1, 2, 3); tick("t3_ld");
        set_in(0, 0, 1, 0, 1, 2, 0); tick("t3_a");
        tick("t3_b");
        check("t3_sat", int'(q10), 0);
        tick("t3_c");
        check("t3_evt_again", int'(evt10), 1);
        check("t3_tc0", int'(tc10), 1);
        dir = 1'b1;
        #1;
        check("t3_tc_dir", int'(tc10), 0);

        // Clamp rules.
        set_in(0, 1, 0, 1, 0, 7, 15); tick("t4_clamp");
        check("t4_clamp_const", int'(q10), 9);
        set_in(0, 1, 0, 1, 0, 7, 5); tick("t4_ld5");
        set_in(0, 0, 1, 1, 0, 7, 0); tick("t4_step7");
        check("t4_step7_const", int'(q10), 2);
        set_in(0, 0, 1, 1, 0, 0, 0); tick("t4_step0");

        // Full-range binary wrap on the MODULUS=16 instance.
        set_in(1, 0, 0, 1, 0, 1, 0); tick("t5_clr");
        set_in(0, 0, 1, 1, 0, 1, 0);
        for (int i = 0; i < 15; i++) tick("t5_up");
        check("t5_top", int'(q16), 15);
        tick("t5_wrap");
        check("t5_wrap_const", int'(q16), 0);
        check("t5_wrap_evt", int'(evt16), 1);
        dir = 1'b0;
        tick("t5_down");
        check("t5_down_const", int'(q16), 15);

        // Randomised pass with mid-count async clears.
        for (int i = 0; i < 60; i++) begin
            set_in(($urandom % 16) == 0, ($urandom % 8) == 0, ($urandom % 4) != 0,
                   1'($urandom), 1'($urandom), int'($urandom % 8), int'($urandom % 16));
            if ((i % 15) == 7) do_aclr("rnd_aclr");
            else               tick("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
